// File: rtl/json_drive_serializer.sv
// json_drive_serializer: formats a drive command (type + signed wheel speeds
// in hundredths) into the 28-byte JSON frame {"T":t,"L":s0.00,"R":s0.00}\n
// and streams it out over a valid/ready byte interface. A one-deep pending
// slot (latest wins) buffers commands arriving while busy, and a watchdog
// launches a STOP frame when commands cease.
module json_drive_serializer #(
  parameter int SPEED_W        = 11,
  parameter int TIMEOUT_CYCLES = 50_000_000,
  parameter int TO_W           = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cmd_valid,
  input  logic [2:0]                cmd_type,
  input  logic signed [SPEED_W-1:0] cmd_left,
  input  logic signed [SPEED_W-1:0] cmd_right,
  output logic [7:0]                tx_data,
  output logic                      tx_valid,
  input  logic                      tx_ready,
  output logic                      busy,
  output logic                      timeout_stop,
  output logic [7:0]                drop_count
);
  localparam logic [1:0] S_IDLE = 2'd0, S_CONV = 2'd1, S_SEND = 2'd2;
  localparam bit              WD_EN  = (TIMEOUT_CYCLES != 0);
  localparam logic [TO_W-1:0] WD_LIM = TO_W'(TIMEOUT_CYCLES - 1);

  // Command already reduced to sign + clipped 10-bit magnitude.
  typedef struct packed {
    logic [2:0] t;
    logic       l_neg;
    logic [9:0] l_mag;
    logic       r_neg;
    logic [9:0] r_mag;
  } cmd_t;

  // {negative, min(|v|, 999)}; widened so -2^(SPEED_W-1) negates safely.
  function automatic logic [10:0] clip_speed(input logic signed [SPEED_W-1:0] v);
    logic signed [16:0] ext;
    logic [16:0]        mag;
    ext = 17'(v);
    mag = ext[16] ? 17'(-ext) : 17'(ext);
    return {ext[16], (mag > 17'd999) ? 10'd999 : mag[9:0]};
  endfunction

  // One double-dabble step: {bcd[11:0], bin[9:0]}, add-3 then shift left.
  function automatic logic [21:0] dd_step(input logic [21:0] sr);
    logic [21:0] s;
    s = sr;
    for (int n = 0; n < 3; n++)
      if (s[10+4*n +: 4] >= 4'd5) s[10+4*n +: 4] = s[10+4*n +: 4] + 4'd3;
    return {s[20:0], 1'b0};
  endfunction

  function automatic logic [7:0] dig(input logic [3:0] d);
    return 8'h30 + {4'h0, d};
  endfunction

  function automatic logic [7:0] sgn(input logic neg);
    return neg ? 8'h2D : 8'h30;
  endfunction

  logic [1:0]      state;
  logic [3:0]      cnt;
  logic [4:0]      idx;
  logic [TO_W-1:0] wd;
  logic [2:0]      last_t, act_t;
  logic            act_ln, act_rn;
  logic [21:0]     l_sr, r_sr;
  cmd_t            in_cmd, pend, launch_cmd;
  logic            pend_full, launch, last_hs, wd_lim, wd_fire;
  logic [7:0]      byte_sel;

  assign in_cmd.t                  = cmd_type;
  assign {in_cmd.l_neg, in_cmd.l_mag} = clip_speed(cmd_left);
  assign {in_cmd.r_neg, in_cmd.r_mag} = clip_speed(cmd_right);

  assign busy     = (state != S_IDLE);
  assign tx_valid = (state == S_SEND);
  assign tx_data  = tx_valid ? byte_sel : 8'h00;
  assign last_hs  = (state == S_SEND) && tx_ready && (idx == 5'd27);
  assign wd_lim   = (wd == WD_LIM);
  assign wd_fire  = WD_EN && (state == S_IDLE) && !cmd_valid && wd_lim && (last_t != 3'd0);

  // Decide whether a new frame starts this cycle and from which source;
  // a live cmd_valid always beats the pending slot or the watchdog STOP.
  always_comb begin
    launch     = 1'b0;
    launch_cmd = in_cmd;
    if (state == S_IDLE) begin
      launch = cmd_valid || wd_fire;
      if (!cmd_valid) launch_cmd = '0;
    end else if (last_hs) begin
      launch = cmd_valid || pend_full;
      if (!cmd_valid) launch_cmd = pend;
    end
  end

  // Main FSM: launch into CONV, 10 BCD steps + 1 settle clock, then SEND.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      cnt          <= '0;
      idx          <= '0;
      wd           <= '0;
      last_t       <= '0;
      act_t        <= '0;
      act_ln       <= 1'b0;
      act_rn       <= 1'b0;
      l_sr         <= '0;
      r_sr         <= '0;
      timeout_stop <= 1'b0;
    end else begin
      timeout_stop <= wd_fire;
      if (launch) begin
        state  <= S_CONV;
        cnt    <= '0;
        wd     <= '0;
        act_t  <= launch_cmd.t;
        last_t <= launch_cmd.t;
        act_ln <= launch_cmd.l_neg;
        act_rn <= launch_cmd.r_neg;
        l_sr   <= {12'd0, launch_cmd.l_mag};
        r_sr   <= {12'd0, launch_cmd.r_mag};
      end else begin
        case (state)
          S_IDLE: if (WD_EN && !wd_lim) wd <= wd + 1'b1;
          S_CONV: begin
            wd <= '0;
            if (cnt == 4'd10) begin
              state <= S_SEND;
              idx   <= '0;
            end else begin
              cnt  <= cnt + 4'd1;
              l_sr <= dd_step(l_sr);
              r_sr <= dd_step(r_sr);
            end
          end
          S_SEND: begin
            wd <= '0;
            if (tx_ready) begin
              if (idx == 5'd27) state <= S_IDLE;
              else              idx   <= idx + 5'd1;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  // Pending slot and drop counter; the slot is consumed on the final handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend       <= '0;
      pend_full  <= 1'b0;
      drop_count <= '0;
    end else begin
      if (busy && cmd_valid && pend_full && drop_count != 8'hFF)
        drop_count <= drop_count + 8'd1;
      if (last_hs) begin
        pend_full <= 1'b0;
      end else if (busy && cmd_valid) begin
        pend      <= in_cmd;
        pend_full <= 1'b1;
      end
    end
  end

  // Frame byte selection by index.
  always_comb begin
    byte_sel = 8'h00;
    case (idx)
      5'd0:  byte_sel = 8'h7B;
      5'd1:  byte_sel = 8'h22;
      5'd2:  byte_sel = 8'h54;
      5'd3:  byte_sel = 8'h22;
      5'd4:  byte_sel = 8'h3A;
      5'd5:  byte_sel = 8'h30 + {5'd0, act_t};
      5'd6:  byte_sel = 8'h2C;
      5'd7:  byte_sel = 8'h22;
      5'd8:  byte_sel = 8'h4C;
      5'd9:  byte_sel = 8'h22;
      5'd10: byte_sel = 8'h3A;
      5'd11: byte_sel = sgn(act_ln);
      5'd12: byte_sel = dig(l_sr[21:18]);
      5'd13: byte_sel = 8'h2E;
      5'd14: byte_sel = dig(l_sr[17:14]);
      5'd15: byte_sel = dig(l_sr[13:10]);
      5'd16: byte_sel = 8'h2C;
      5'd17: byte_sel = 8'h22;
      5'd18: byte_sel = 8'h52;
      5'd19: byte_sel = 8'h22;
      5'd20: byte_sel = 8'h3A;
      5'd21: byte_sel = sgn(act_rn);
      5'd22: byte_sel = dig(r_sr[21:18]);
      5'd23: byte_sel = 8'h2E;
      5'd24: byte_sel = dig(r_sr[17:14]);
      5'd25: byte_sel = dig(r_sr[13:10]);
      5'd26: byte_sel = 8'h7D;
      5'd27: byte_sel = 8'h0A;
      default: byte_sel = 8'h00;
    endcase
  end
endmodule

// File: tb/tb_json_drive_serializer.sv
// Directed bench for json_drive_serializer: a vector table of commands with
// hand-written expected frames, plus sequences for pending overwrite,
// drop saturation, watchdog STOP and mid-frame reset.
module tb_json_drive_serializer;
  localparam int SW = 11;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 cmd_valid = 1'b0;
  logic [2:0]           cmd_type = '0;
  logic signed [SW-1:0] cmd_left = '0, cmd_right = '0;
  logic [7:0]           tx_data;
  logic                 tx_valid;
  logic                 tx_ready = 1'b1;
  logic                 busy, timeout_stop;
  logic [7:0]           drop_count;

  int         checks = 0, errors = 0;
  logic [7:0] rxq[$];
  int         pulses = 0;
  bit         rdy_rand = 1'b0, rdy_val = 1'b1;

  typedef struct {
    logic [2:0]   t;
    int           l;
    int           r;
    bit           rnd;
    logic [223:0] exp;
  } vec_t;
  vec_t vt[8];

  json_drive_serializer #(.SPEED_W(SW), .TIMEOUT_CYCLES(100), .TO_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_type(cmd_type),
    .cmd_left(cmd_left), .cmd_right(cmd_right), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy),
    .timeout_stop(timeout_stop), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  // tx_ready: constant or ~70% random, changed just after the falling edge.
  initial forever begin
    @(negedge clk); #1;
    tx_ready = rdy_rand ? ($urandom_range(0, 99) >= 30) : rdy_val;
  end

  // Byte collector, stall-hold checker and pulse counter, sampled 1ns before posedge.
  initial begin
    bit         prev_stall;
    logic [7:0] prev_data;
    prev_stall = 1'b0;
    prev_data  = '0;
    forever begin
      @(negedge clk); #4;
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          checks++;
          if (!tx_valid || tx_data !== prev_data) begin
            errors++;
            $display("FAIL stall_hold: valid=%b data=%h required valid=1 data=%h", tx_valid, tx_data, prev_data);
          end
        end
        if (tx_valid && tx_ready) rxq.push_back(tx_data);
        if (timeout_stop) pulses++;
        prev_stall = tx_valid && !tx_ready;
        prev_data  = tx_data;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", nm, act, exp);
    end
  endtask

  task automatic send_cmd(input logic [2:0] t, input int l, input int r);
    @(negedge clk); #1;
    cmd_valid = 1'b1; cmd_type = t; cmd_left = l[SW-1:0]; cmd_right = r[SW-1:0];
    @(negedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_bytes(input string nm, input int n, input int budget);
    int b;
    b = 0;
    while (rxq.size() < n && b < budget) begin
      @(posedge clk); #2;
      b++;
    end
    chk(nm, rxq.size() >= n, 1);
  endtask

  task automatic wait_valid(input string nm);
    int b;
    b = 0;
    while (!tx_valid && b < 40) begin
      @(posedge clk); #2;
      b++;
    end
    chk(nm, tx_valid, 1);
  endtask

  task automatic check_frame(input string nm, input logic [223:0] exp, input int base);
    int         bad;
    logic [7:0] e, g;
    bad = -1;
    e   = '0;
    g   = '0;
    for (int i = 0; i < 28; i++) begin
      if (bad < 0) begin
        e = exp[(27-i)*8 +: 8];
        g = (base + i < rxq.size()) ? rxq[base+i] : 8'hxx;
        if (g !== e) bad = i;
      end
    end
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL %s: byte %0d got %h required %h", nm, bad, g, e);
    end
  endtask

  task automatic do_reset();
    @(negedge clk); #1;
    rst_n = 1'b0; cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    rxq.delete();
  endtask

  initial begin
    int k, j, p0;
    vt[0] = '{t:3'd1, l:-30,   r:20,    rnd:1'b0, exp:"{\"T\":1,\"L\":-0.30,\"R\":00.20}\n"};
    vt[1] = '{t:3'd2, l:1023,  r:-1024, rnd:1'b0, exp:"{\"T\":2,\"L\":09.99,\"R\":-9.99}\n"};
    vt[2] = '{t:3'd3, l:0,     r:-5,    rnd:1'b0, exp:"{\"T\":3,\"L\":00.00,\"R\":-0.05}\n"};
    vt[3] = '{t:3'd7, l:999,   r:-999,  rnd:1'b0, exp:"{\"T\":7,\"L\":09.99,\"R\":-9.99}\n"};
    vt[4] = '{t:3'd4, l:1000,  r:123,   rnd:1'b0, exp:"{\"T\":4,\"L\":09.99,\"R\":01.23}\n"};
    vt[5] = '{t:3'd5, l:-1000, r:998,   rnd:1'b0, exp:"{\"T\":5,\"L\":-9.99,\"R\":09.98}\n"};
    vt[6] = '{t:3'd1, l:-30,   r:20,    rnd:1'b1, exp:"{\"T\":1,\"L\":-0.30,\"R\":00.20}\n"};
    vt[7] = '{t:3'd6, l:-1,    r:1,     rnd:1'b1, exp:"{\"T\":6,\"L\":-0.01,\"R\":00.01}\n"};

    // Reset state
    #12;
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_drop", drop_count, 0);
    chk("rst_timeout_stop", timeout_stop, 0);
    @(negedge clk); #1 rst_n = 1'b1;

    // Table-driven frames: latency, content, busy release
    for (int v = 0; v < 8; v++) begin
      rxq.delete();
      rdy_rand = vt[v].rnd;
      send_cmd(vt[v].t, vt[v].l, vt[v].r);
      #3;
      k = 0;
      while (!tx_valid && k < 40) begin #10; k++; end
      chk($sformatf("latency_v%0d", v), k, 11);
      chk($sformatf("first_byte_v%0d", v), tx_data, 8'h7B);
      wait_bytes($sformatf("bytes_v%0d", v), 28, 300);
      check_frame($sformatf("frame_v%0d", v), vt[v].exp, 0);
      chk($sformatf("busy_after_v%0d", v), busy, 0);
    end
    rdy_rand = 1'b0;

    // Pending: A sent, B overwritten by C, C follows A
    rxq.delete();
    send_cmd(3'd1, 100, -100);
    wait_valid("pend_a_valid");
    send_cmd(3'd2, 1, 2);
    send_cmd(3'd3, 5, 6);
    wait_bytes("pend_bytes", 56, 300);
    check_frame("pend_frame_a", "{\"T\":1,\"L\":01.00,\"R\":-1.00}\n", 0);
    check_frame("pend_frame_c", "{\"T\":3,\"L\":00.05,\"R\":00.06}\n", 28);
    chk("pend_drop", drop_count, 1);

    // Drop saturation: 1 fill + 260 overwrites while stalled
    do_reset();
    rdy_val = 1'b0;
    send_cmd(3'd1, 0, 0);
    for (int i = 0; i < 261; i++) begin
      @(negedge clk); #1;
      cmd_valid = 1'b1;
      if (i == 260) begin cmd_type = 3'd6; cmd_left = -11'sd999; cmd_right = 11'sd7; end
      else begin cmd_type = 3'd2; cmd_left = 11'(i); cmd_right = '0; end
    end
    @(negedge clk); #1 cmd_valid = 1'b0;
    chk("drop_saturate", drop_count, 255);
    rdy_val = 1'b1;
    wait_bytes("sat_bytes", 56, 300);
    check_frame("sat_frame_a", "{\"T\":1,\"L\":00.00,\"R\":00.00}\n", 0);
    check_frame("sat_frame_last", "{\"T\":6,\"L\":-9.99,\"R\":00.07}\n", 28);

    // Watchdog: STOP after 100 idle clocks, only once
    do_reset();
    pulses = 0;
    send_cmd(3'd1, -30, 20);
    wait_bytes("wd_cmd_bytes", 28, 300);
    j = 0;
    while (!timeout_stop && j < 200) begin @(posedge clk); #2; j++; end
    checks++;
    if (j < 100 || j > 101) begin
      errors++;
      $display("FAIL wd_delay: pulse after %0d idle clocks required 100", j);
    end
    wait_bytes("wd_stop_bytes", 56, 300);
    check_frame("wd_stop_frame", "{\"T\":0,\"L\":00.00,\"R\":00.00}\n", 28);
    repeat (500) @(posedge clk);
    chk("wd_single_pulse", pulses, 1);
    chk("wd_no_second_stop", rxq.size(), 56);

    // Watchdog: cmd_valid on the expiry cycle wins, no pulse
    rxq.delete();
    send_cmd(3'd2, 1023, -1024);
    wait_bytes("wdx_bytes", 28, 300);
    p0 = pulses;
    repeat (99) @(posedge clk);
    @(negedge clk); #1;
    cmd_valid = 1'b1; cmd_type = 3'd5; cmd_left = -11'sd20; cmd_right = 11'sd20;
    @(negedge clk); #1 cmd_valid = 1'b0;
    wait_bytes("wdx_cmd_bytes", 56, 300);
    check_frame("wdx_cmd_frame", "{\"T\":5,\"L\":-0.20,\"R\":00.20}\n", 28);
    repeat (20) @(posedge clk);
    chk("wdx_no_pulse", pulses, p0);

    // Async reset at byte 12 aborts frame and clears drop_count
    do_reset();
    send_cmd(3'd1, 100, -100);
    wait_valid("rst_a_valid");
    send_cmd(3'd2, 1, 2);
    send_cmd(3'd3, 5, 6);
    wait_bytes("rst_12_bytes", 12, 100);
    chk("rst_pre_drop", drop_count, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", tx_valid, 0);
    chk("rst_mid_drop", drop_count, 0);
    chk("rst_mid_busy", busy, 0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    rxq.delete();
    send_cmd(3'd1, -30, 20);
    wait_bytes("rst_after_bytes", 28, 300);
    check_frame("rst_after_frame", "{\"T\":1,\"L\":-0.30,\"R\":00.20}\n", 0);
    repeat (30) @(posedge clk);
    chk("rst_no_stale_pending", rxq.size(), 28);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
